// File: rtl/dmem_ctrl.sv
// Byte/half/word data memory with req/ready handshake, synchronous reads of
// configurable latency, and error responses for misaligned/out-of-range/illegal accesses.
module dmem_ctrl #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       rd
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = ADDR_W - 2;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  lane;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] data;
    } ld_t;

    logic [31:0]   mem [DEPTH];
    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    ld_t           pipe [READ_LAT];
    ld_t           last;
    logic          sr_valid, sr_err;
    logic [WW-1:0] widx;
    logic [IW-1:0] ridx;
    logic          accept, bad, ld_ok, st_ok;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ext;

    assign widx   = addr[ADDR_W-1:2];
    assign ridx   = widx[IW-1:0];
    assign ready  = (state == IDLE) & ~reset;
    assign accept = req & ready;
    assign bad    = (widx >= WW'(DEPTH)) | (size == 2'b11) |
                    ((size == 2'b01) & addr[0]) |
                    ((size == 2'b10) & (addr[1:0] != 2'b00));
    assign ld_ok  = accept & ~we & ~bad;
    assign st_ok  = accept & we & ~bad;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        be     = 4'b0000;
        wlanes = wd;
        case (size)
            2'b00: begin
                be[addr[1:0]] = 1'b1;
                wlanes        = {4{wd[7:0]}};
            end
            2'b01: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wd[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // NOTE: RAM contents are deliberately not reset; only control state is.
    always_ff @(posedge clk) begin
        if (st_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[ridx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end

    // Load pipeline: stage 0 captures the RAM word at the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) pipe[i].valid <= 1'b0;
            sr_valid <= 1'b0;
            sr_err   <= 1'b0;
        end else begin
            pipe[0].valid <= ld_ok;
            pipe[0].lane  <= addr[1:0];
            pipe[0].size  <= size;
            pipe[0].sext  <= sext;
            pipe[0].data  <= mem[ridx];
            for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
            sr_valid <= accept & (we | bad);
            sr_err   <= accept & bad;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ld_ok && (READ_LAT > 1)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 3'(READ_LAT - 1);
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last = pipe[READ_LAT-1];

    always_comb begin
        lane_b = last.data[{last.lane, 3'b000} +: 8];
        lane_h = last.lane[1] ? last.data[31:16] : last.data[15:0];
        case (last.size)
            2'b00:   ext = {{24{last.sext & lane_b[7]}}, lane_b};
            2'b01:   ext = {{16{last.sext & lane_h[15]}}, lane_h};
            default: ext = last.data;
        endcase
        rd = last.valid ? ext : 32'd0;
    end

    assign resp_valid = last.valid | sr_valid;
    assign resp_err   = sr_err;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data memory for the single-cycle/multicycle ARM datapath. Replaces the fixed word-only, combinational-read store.
- Adds byte, halfword and word loads and stores, with sign or zero extension on loads.
- Reads are synchronous with a configurable latency. Requests use a req/ready handshake and every request gets a response pulse.
- Misaligned, out-of-range and illegal-size accesses are flagged as errors instead of corrupting memory.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two not required, ≥2).
- ADDR_W, 32, byte-address width.
- READ_LAT, 1, cycles from load acceptance to response (legal 1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid.
- ready  out  1  block can accept a request this cycle.
- we  in  1  1=store, 0=load (sampled on accept).
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sext  in  1  loads: 1=sign-extend, 0=zero-extend; ignored for stores.
- addr  in  ADDR_W  byte address.
- wd  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse, one per accepted request.
- resp_err  out  1  valid with resp_valid; 1=request rejected.
- rd  out  32  load data, valid with resp_valid for a non-error load; 0 otherwise.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: resp_valid=0, resp_err=0, rd=0, latency counter=0, state IDLE. ready=0 during reset and 1 in the first cycle after reset deasserts. RAM contents are not reset.
- Reset mid-operation: an in-flight load is dropped with no response.
- Accept: accept = req & ready, evaluated at the rising edge. Inputs are ignored when accept=0.
- Word index: addr[ADDR_W-1:2].
- Error conditions (any one makes the request an error):
  - word index ≥ DEPTH;
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠00.
- Error handling: no RAM write. resp_valid=1, resp_err=1, rd=0 in the cycle after the accept edge. ready stays 1.
- Store (legal): RAM updated at the accept edge. Only the addressed lanes change, little-endian:
  - byte lane k=addr[1:0] gets wd[7:0] in bits [8k+7:8k];
  - half lane addr[1] gets wd[15:0];
  - word writes all 32 bits.
  - resp_valid=1, resp_err=0, rd=0 in the next cycle. ready stays 1.
- Load (legal):
  - The RAM word is read at the accept edge. Lane, size and sext are captured at the same edge.
  - A pipeline of READ_LAT-1 registers carries the data. resp_valid=1 exactly READ_LAT cycles after the accept edge.
  - rd = selected lane, extended to 32 bits: sext=1 replicates bit 7 (byte) or bit 15 (half); sext=0 zero-fills.
- State machine:
  - States: IDLE, BUSY.
  - IDLE→BUSY on a load accept when READ_LAT>1. The counter is loaded with READ_LAT-1.
  - BUSY decrements the counter. BUSY→IDLE when the counter reaches 1, so the block is IDLE in the response cycle.
  - ready = (state==IDLE) & ~reset. ready is low for READ_LAT-1 cycles after a load accept.
  - With READ_LAT=1 the block never leaves IDLE.
- Back-to-back requests: a request may be accepted in a response cycle; its response follows that one with no overlap. At most one response is pending per cycle.
- Read-after-write: a load accepted in the cycle right after a store to the same word returns the updated data. No bypass is needed because the write happens at the store's accept edge.
- Simultaneous req and reset: reset wins. No write, no response.

Test Plan:
1. Word store then load, READ_LAT=1: store 0xDEADBEEF @0x10, then load word @0x10 → resp_valid pulses 1 cycle after each accept; load rd=0xDEADBEEF, resp_err=0.
2. Byte lanes: word 0x00000000 @0x20, store byte 0xA5 @0x22, then:
   - word load → 0x00A50000;
   - byte load @0x22 with sext=1 → 0xFFFFFFA5;
   - byte load with sext=0 → 0x000000A5.
3. Half lane: store half 0x8001 @0x32, then half load @0x32 with sext=1 → 0xFFFF8001. Half load @0x30 returns the untouched low half.
4. Errors:
   - word store @0x13 → resp_err=1, memory @0x10 unchanged;
   - half load @0x41 → err, rd=0;
   - size=11 → err;
   - addr=DEPTH*4 → err.
5. READ_LAT=3: load accepted at edge N → ready=0 for 2 cycles, resp_valid high exactly 3 cycles after edge N, req held during busy cycles is not accepted until ready=1.
6. Reset mid-load (READ_LAT=3), reset one cycle after accept → no resp_valid ever for that load. ready=1 the cycle after reset drops; the next load returns correct data.
